// File: rtl/mvm_pkg.sv
// mvm_pkg: FSM states and default sizing shared by the weight feeder and the MVM
package mvm_pkg;
    localparam int N_DEF       = 4;
    localparam int DW_DEF      = 4;
    localparam int TIMEOUT_DEF = 255;
    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, DONE} state_t;
endpackage

// File: rtl/mvm_wbuf.sv
// mvm_wbuf: N*N x DW weight registers, one write port and one combinational read port
module mvm_wbuf
    import mvm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [$clog2(N*N)-1:0] wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic [$clog2(N*N)-1:0] rd_addr,
    output logic [DW-1:0]          rd_data
);
    logic [N*N-1:0][DW-1:0] mem;
    // weight storage, wiped by reset
    always_ff @(posedge clk or posedge rst)
        if (rst) mem <= '0;
        else if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mvm_wfeed.sv
// mvm_wfeed: streams the stored weights to the MVM, waits for it and captures its result
module mvm_wfeed
    import mvm_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   i_clk_wf,
    input  logic                   i_rst_wf,
    input  logic                   i_wr_en,
    input  logic [$clog2(N*N)-1:0] i_wr_addr,
    input  logic [DW-1:0]          i_wr_data,
    input  logic                   i_go,
    output logic                   o_start_mvm,
    output logic [DW-1:0]          o_w_mvm,
    input  logic                   i_ismvm,
    input  logic [N-1:0][DW-1:0]   i_wx_result,
    output logic [N-1:0][DW-1:0]   o_result,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout
);
    localparam int AW = $clog2(N*N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] K_LAST = AW'(N*N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
    state_t        state, state_nx;
    logic [AW-1:0] k;
    logic [CW-1:0] cnt;
    logic          seen_busy, fin, to;
    logic [DW-1:0] w_rd;
    mvm_wbuf #(.N(N), .DW(DW)) u_wbuf (
        .clk     (i_clk_wf),
        .rst     (i_rst_wf),
        .wr_en   (i_wr_en && state == IDLE),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_addr (k),
        .rd_data (w_rd)
    );
    // normal completion has priority over a timeout landing on the same cycle;
    // the counter holds 0..TIMEOUT-1, so the abort fires on the TIMEOUT-th WAIT cycle
    assign fin = state == WAIT && seen_busy && !i_ismvm;
    assign to  = state == WAIT && !fin && cnt == C_LAST;
    // state register
    always_ff @(posedge i_clk_wf or posedge i_rst_wf)
        if (i_rst_wf) state <= IDLE;
        else state <= state_nx;
    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_go) state_nx = START;
            START:   state_nx = STREAM;
            STREAM:  if (k == K_LAST) state_nx = WAIT;
            WAIT:    if (fin || to) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state-decoded outputs; the weight bus is forced to zero outside STREAM
    always_comb begin
        o_start_mvm = state == START;
        o_w_mvm     = state == STREAM ? w_rd : '0;
        o_busy      = state != IDLE;
        o_done      = state == DONE;
    end
    // stream index, wait counter, busy tracking, timeout flag and result capture
    always_ff @(posedge i_clk_wf or posedge i_rst_wf) begin
        if (i_rst_wf) begin
            k         <= '0;
            cnt       <= '0;
            seen_busy <= 1'b0;
            o_result  <= '0;
            o_timeout <= 1'b0;
        end else begin
            k         <= state == STREAM && k != K_LAST ? k + AW'(1) : '0;
            cnt       <= state == WAIT ? cnt + CW'(1) : '0;
            seen_busy <= state == IDLE ? 1'b0 : state == START ? i_ismvm : seen_busy | i_ismvm;
            o_timeout <= state == IDLE && i_go ? 1'b0 : o_timeout | to;
            if (fin) o_result <= i_wx_result;
        end
    end
endmodule

// File: tb/tb_mvm_wfeed.sv
// tb_mvm_wfeed: directed stimulus checked every cycle against a transaction-level model
module tb_mvm_wfeed;
    localparam int N = 4, DW = 4, TO = 255, NN = 16;
    logic clk = 0, rst = 1, wr_en = 0, go = 0, ismvm = 0;
    logic [3:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [N-1:0][DW-1:0] wx_result = '0, result;
    logic start_mvm, busy, done, timeout;
    logic [DW-1:0] w_mvm;
    int checks = 0, failures = 0;

    mvm_wfeed #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk_wf    (clk),
        .i_rst_wf    (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_go        (go),
        .o_start_mvm (start_mvm),
        .o_w_mvm     (w_mvm),
        .i_ismvm     (ismvm),
        .i_wx_result (wx_result),
        .o_result    (result),
        .o_busy      (busy),
        .o_done      (done),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: 'a' is the cycle number since go was accepted (1 = start pulse,
    // 2..17 = weight k=a-2, 18.. = waiting), -1 while idle
    logic [DW-1:0] mw [NN];
    int a = -1;
    logic m_seen = 0, m_fin = 0, m_to = 0;
    logic [15:0] m_res = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mw[i]) mw[i] = '0;
            a = -1; m_seen = 0; m_fin = 0; m_to = 0; m_res = '0;
        end else if (a < 0) begin
            if (wr_en) mw[wr_addr] = wr_data;
            if (go) begin a = 1; m_seen = 0; m_to = 0; end
        end else if (m_fin) begin
            a = -1; m_fin = 0;
        end else begin
            if (a >= 18 && m_seen && !ismvm) begin m_fin = 1; m_res = wx_result; end
            else if (a >= 18 && a - 18 == TO - 1) begin m_fin = 1; m_to = 1; end
            else a++;
            m_seen = m_seen | ismvm;
        end
    end

    // compare, transaction monitor and a scripted MVM that stays busy mvm_lat cycles
    int cyc = 0, mvm_cnt = 0, mvm_lat = 20;
    logic mvm_on = 1;
    logic [15:0] mvm_res = 16'hCCCC;
    int start_c = -1000, done_c = -1000, n_done = 0, n_start = 0;
    int gaps[$];
    logic [DW-1:0] ws[$];
    always @(negedge clk) begin
        cyc++;
        chk("o_start_mvm", 64'(start_mvm), 64'(a == 1));
        chk("o_w_mvm", 64'(w_mvm), (a >= 2 && a <= 17) ? 64'(mw[a-2]) : 64'(0));
        chk("o_busy", 64'(busy), 64'(a >= 1));
        chk("o_done", 64'(done), 64'(m_fin));
        chk("o_result", 64'(result), 64'(m_res));
        chk("o_timeout", 64'(timeout), 64'(m_to));
        if (start_mvm) begin
            gaps.push_back(cyc - done_c);
            start_c = cyc; n_start++; ws.delete();
        end
        if (cyc > start_c && cyc <= start_c + NN) ws.push_back(w_mvm);
        if (done) begin n_done++; done_c = cyc; end
        if (start_mvm && mvm_on) mvm_cnt = mvm_lat;
        ismvm = mvm_cnt > 0;
        if (mvm_cnt > 0) mvm_cnt--;
        wx_result = mvm_res;
    end

    function automatic logic [63:0] pack_ws();
        logic [63:0] p = '0;
        foreach (ws[i]) if (i < NN) p[i*4 +: 4] = ws[i];
        return p;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wr(input int ad, input int d);
        wr_en = 1; wr_addr = 4'(ad); wr_data = 4'(d);
        tick();
        wr_en = 0;
    endtask

    // one transaction: optional write on the go edge, optional write mid-flight
    task automatic txn(output int go_c, input logic co_w, input int co_a, input int co_d,
                       input int mid_at, input int mid_a, input int mid_d);
        go = 1; go_c = cyc;
        wr_en = co_w; wr_addr = 4'(co_a); wr_data = 4'(co_d);
        tick();
        go = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            wr_en = (i == mid_at); wr_addr = 4'(mid_a); wr_data = 4'(mid_d);
            tick();
        end
        wr_en = 0;
        chk("txn_done_seen", 64'(done), 64'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, nd;
        tick(3);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_w", 64'(w_mvm), 64'(0));
        rst = 0;
        tick(2);
        // all weights 8, MVM answers 0xC per element
        for (int i = 0; i < NN; i++) wr(i, 8);
        nd = n_done;
        txn(g, 0, 0, 0, -1, 0, 0);
        chk("all8_start_cycle", 64'(start_c - g), 64'(1));
        chk("all8_len", 64'(ws.size()), 64'(NN));
        chk("all8_stream", pack_ws(), 64'h8888_8888_8888_8888);
        chk("all8_result", 64'(result), 64'hCCCC);
        chk("all8_one_done", 64'(n_done - nd), 64'(1));
        // ascending weights
        for (int i = 0; i < NN; i++) wr(i, i);
        mvm_res = 16'h1234;
        txn(g, 0, 0, 0, -1, 0, 0);
        chk("ramp_stream", pack_ws(), 64'hFEDC_BA98_7654_3210);
        chk("ramp_result", 64'(result), 64'h1234);
        // write during STREAM is dropped
        mvm_res = 16'h5678;
        txn(g, 0, 0, 0, 3, 5, 3);
        txn(g, 0, 0, 0, -1, 0, 0);
        chk("drop_stream", pack_ws(), 64'hFEDC_BA98_7654_3210);
        // MVM never busy: timeout after 255 WAIT cycles, result kept
        mvm_on = 0; mvm_res = 16'h9999;
        txn(g, 0, 0, 0, -1, 0, 0);
        chk("to_wait_cycles", 64'(done_c - start_c - 17), 64'(255));
        chk("to_flag", 64'(timeout), 64'(1));
        chk("to_result_kept", 64'(result), 64'h5678);
        // write together with go lands in the stream; timeout clears
        mvm_on = 1; mvm_res = 16'hCCCC;
        txn(g, 1, 0, 9, -1, 0, 0);
        chk("cowrite_stream", pack_ws(), 64'hFEDC_BA98_7654_3219);
        chk("cowrite_to_clr", 64'(timeout), 64'(0));
        // reset in the sixth STREAM cycle
        go = 1; tick(); go = 0;
        while (cyc < start_c + 6) tick();
        chk("pre_rst_w", 64'(w_mvm), 64'(5));
        #1 rst = 1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_w", 64'(w_mvm), 64'(0));
        chk("rst_mid_done", 64'(done), 64'(0));
        tick(2);
        rst = 0;
        nd = n_done;
        tick(30);
        chk("rst_no_done", 64'(n_done - nd), 64'(0));
        txn(g, 0, 0, 0, -1, 0, 0);
        chk("rst_buf_clear", pack_ws(), 64'h0);
        // go held for 40 cycles: exactly two back-to-back transactions
        for (int i = 0; i < NN; i++) wr(i, 15 - i);
        mvm_lat = 3;
        gaps.delete(); nd = n_start;
        go = 1; tick(40); go = 0;
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("b2b_starts", 64'(n_start - nd), 64'(2));
        chk("b2b_gap", gaps.size() >= 2 ? 64'(gaps[1]) : 64'(0), 64'(2));
        chk("b2b_idle", 64'(busy), 64'(0));
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mvm_wfeed.md
MVM_WFEED -- requirements
Module: mvm_wfeed

Interface
REQ-001 Parameter N, default 4, vector length and number of weight rows/columns (weight buffer depth N*N).
REQ-002 Parameter DW, default 4, weight, vector and result element width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 i_clk_wf  input  1  clock, all state on rising edge.
REQ-006 i_rst_wf  input  1  async active-high reset.
REQ-007 i_wr_en  input  1  weight buffer write strobe.
REQ-008 i_wr_addr  input  log2(N*N)  weight entry index, row-major.
REQ-009 i_wr_data  input  DW  weight value.
REQ-010 i_go  input  1  start-transaction request, sampled in IDLE only.
REQ-011 o_start_mvm  output  1  one-cycle start pulse to MVM.
REQ-012 o_w_mvm  output  DW  serial weight stream to MVM.
REQ-013 i_ismvm  input  1  MVM busy indicator.
REQ-014 i_wx_result  input  N x DW  MVM result vector.
REQ-015 o_result  output  N x DW  captured result, held until next capture.
REQ-016 o_busy  output  1  high in every state except IDLE.
REQ-017 o_done  output  1  one-cycle completion pulse.
REQ-018 o_timeout  output  1  sticky: last transaction aborted on timeout; cleared at next START.

Function
REQ-019 FSM states SHALL be IDLE, START, STREAM, WAIT and DONE.
REQ-020 IDLE->START when i_go=1; otherwise the FSM SHALL stay in IDLE.
REQ-021 START SHALL last exactly one cycle with o_start_mvm=1, then go to STREAM.
REQ-022 STREAM SHALL drive o_w_mvm=buf[k] for k=0..N*N-1, one entry per cycle in ascending order, then go to WAIT; o_w_mvm SHALL be 0 outside STREAM.
REQ-023 A sticky seen_busy flag SHALL clear in START and set whenever i_ismvm=1 from START onward.
REQ-024 WAIT->DONE in the first cycle where seen_busy=1 and i_ismvm=0; i_wx_result SHALL be registered into o_result on that edge.
REQ-025 A WAIT cycle counter SHALL start at 0; when it reaches TIMEOUT, the FSM SHALL go to DONE, set o_timeout=1 and leave o_result unchanged.
REQ-026 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-027 Latency: i_go sampled at edge 0 gives o_start_mvm in cycle 1, buf[0] in cycle 2 and buf[N*N-1] in cycle N*N+1.
REQ-028 Writes SHALL take effect only when the FSM is in IDLE; writes in any other state SHALL be dropped.
REQ-029 When i_wr_en and i_go are both sampled in IDLE on the same edge, the write SHALL complete and the stream SHALL use the new value.
REQ-030 i_go outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear all weight entries, counters, seen_busy, o_result, o_timeout, o_start_mvm, o_w_mvm and o_done to 0, asynchronously.
REQ-032 Reset mid-transaction SHALL abort immediately, with no o_done pulse after release.

Structure
REQ-033 The state enum and the N, DW and TIMEOUT defaults SHALL live in a shared package mvm_pkg, also used by MVM.
REQ-034 The weight buffer SHALL be a sub-module mvm_wbuf: N*N x DW registers, one write port and one combinational read port.

Verification
REQ-035 All 16 weights=8 and an MVM model returning 4'hC per element -> o_start_mvm in cycle 1, o_w_mvm=8 in cycles 2..17, o_result={C,C,C,C}, one o_done pulse.
REQ-036 Weights buf[k]=k -> o_w_mvm sequence 0,1,...,15 with no gaps or repeats.
REQ-037 i_ismvm held 0 throughout -> DONE after 255 WAIT cycles, o_timeout=1, o_result keeps its previous value.
REQ-038 Write addr 5 = 4'h3 while in STREAM -> buf[5] unchanged; the next transaction streams the old value.
REQ-039 Reset asserted in cycle 6 of STREAM -> o_busy=0 and o_w_mvm=0 immediately, all buffer entries 0, no o_done.
REQ-040 i_go held high for 40 cycles -> back-to-back transactions, each starting in the cycle after IDLE is re-entered.
